counter_bank: RTL
=================

# counter_bank

Parametrised bank of N_CH independent modulo-MOD counters driven by per-channel push buttons, with a runtime-selectable number of active channels, per-channel wrap detection and a shared buzzer-tone generator. It replaces the fixed 10-object, generate-selected adder arrangement in the game datapath. Counter values feed display logic; the tone output drives the buzzer pin directly.

## Interface
- N_CH, 10: number of channels (1..16)
- W, 4: counter width per channel
- MOD, 10: counter modulus (2 ≤ MOD ≤ 2^W)
- INIT, 1: reset/clear value of every counter (INIT < MOD)
- BEEP_CYCLES, 50_000_000: beep duration in clk cycles after the last wrap
- TONE_HALF, 25_000: half-period of the tone square wave in clk cycles
- CW, $clog2(N_CH+1): width of active_cnt
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- tick  in  1  button sample strobe, one clk wide (typically the clkdiv[17] rising edge)
- en  in  1  counting enable; when 0, edges are consumed but do not count
- clear  in  1  synchronous reload of all counters to INIT
- active_cnt  in  CW  number of active channels, counted from channel 0
- btn  in  N_CH  per-channel buttons, level, externally debounced
- values  out  N_CH*W  packed counters, channel i at [i*W +: W]
- wrap  out  N_CH  one-cycle pulse per channel on MOD-1 → 0
- beeping  out  1  level, high while the beep timer runs
- beep  out  1  tone square wave while beeping, else 0

## Operation
- Reset: all counters = INIT, wrap = 0, beeping = 0, beep = 0, tone and beep counters = 0, button sample register = all ones. A button held through reset is not counted until it is released and pressed again.
- Sampling: only in cycles with tick = 1. Then press[i] = btn[i] & ~last[i] and last ← btn. Between ticks, btn is ignored.
- Channel i is active iff i < min(active_cnt, N_CH). active_cnt = 0 disables all channels.
- Counting: in a tick cycle with press[i] = 1, en = 1 and channel i active:
  - counter[i] ← counter[i] + 1, or 0 if it is MOD-1;
  - on the MOD-1 → 0 case, wrap[i] = 1 for exactly the next cycle.
- Inactive channels hold their values, including across changes of active_cnt. A channel that becomes inactive keeps its value and resumes from it when reactivated.
- clear = 1: every counter ← INIT, no wrap, and last is still updated if tick = 1. clear has priority over a simultaneous press.
- Beep: any wrap bit loads the beep timer with BEEP_CYCLES-1 and sets beeping. A new wrap while beeping restarts the full duration. beeping drops when the timer reaches 0.
- Tone: while beeping, beep toggles every TONE_HALF cycles, starting at 1. When not beeping, beep = 0 and the tone counter is held at 0.
- rst mid-operation overrides everything, including an in-progress beep.

## Timing
- Press-to-value latency: 1 cycle. values reflect the press on the clock edge that closes the tick cycle.
- wrap[i] and beeping rise in the same cycle that values shows 0. beep rises in that same cycle.
- Several channels may wrap in the same cycle; each of their wrap bits pulses.
- beeping stays high for exactly BEEP_CYCLES cycles after the last wrap.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package counter_bank_pkg holds the default constants for N_CH, W, MOD, INIT, BEEP_CYCLES and TONE_HALF, plus elaboration assertions on MOD ≤ 2^W and INIT < MOD.
- Sub-module mod_counter_ch, generated N_CH times: the per-channel edge register, counter, wrap pulse and active gating.
- The beep timer and tone divider stay in the top of counter_bank.

## Test plan
- Reset with btn[0] held high, then tick → values[0] = 1 and no count. Release, tick, press, tick → values[0] = 2.
- Nine presses on channel 3 with active_cnt = 4, INIT = 1 → values[3] = 0 after the 9th, wrap[3] pulses one cycle, beeping rises the same cycle.
- active_cnt = 2 and presses on channels 0–5 → only channels 0 and 1 increment. Set active_cnt = 6 → channels 2–5 resume from 1.
- clear and press on channel 0 in the same tick cycle → values[0] = 1 and no wrap. en = 0 with presses → no change.
- With BEEP_CYCLES = 100 and TONE_HALF = 5: wrap, then a second wrap at cycle 60 → beeping lasts through cycle 159, and beep has a 10-cycle period, starting at 1.
- Channels 0 and 9 both at 9, pressed in the same tick with N_CH = 10 → both go to 0 and both wrap bits pulse. Assert rst during the beep → beep = 0 on the next cycle.

Source files
------------

// File: rtl/counter_bank_pkg.sv
// Shared defaults for the counter bank and a parameter sanity check used at elaboration.
package counter_bank_pkg;
  localparam int N_CH_DEF        = 10;
  localparam int W_DEF           = 4;
  localparam int MOD_DEF         = 10;
  localparam int INIT_DEF        = 1;
  localparam int BEEP_CYCLES_DEF = 50_000_000;
  localparam int TONE_HALF_DEF   = 25_000;

  function automatic bit params_ok(input int w, input int modv, input int init);
    return (w >= 1) && (w <= 30) && (modv >= 2) && (modv <= (1 << w))
        && (init >= 0) && (init < modv);
  endfunction
endpackage

// File: rtl/mod_counter_ch.sv
// One channel: button edge detect on tick, modulo counter with clear and active gating,
// registered wrap pulse; wrap_nxt lets the top line up the beep with the wrap.
module mod_counter_ch
  import counter_bank_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int MOD  = MOD_DEF,
  parameter int INIT = INIT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         en,
  input  logic         clear,
  input  logic         active,
  input  logic         btn,
  output logic [W-1:0] value,
  output logic         wrap,
  output logic         wrap_nxt
);
  localparam logic [W-1:0] MAX_V  = W'(MOD - 1);
  localparam logic [W-1:0] INIT_V = W'(INIT);

  logic         last_q, last_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         wrap_q, wrap_d;
  logic         press;

  always_comb begin
    press  = tick & btn & ~last_q;
    last_d = tick ? btn : last_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (clear) begin
      cnt_d = INIT_V;
    end else if (press && en && active) begin
      if (cnt_q == MAX_V) begin
        cnt_d  = '0;
        wrap_d = 1'b1;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  // last resets high so a button held through reset needs a fresh press
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
      cnt_q  <= INIT_V;
      wrap_q <= 1'b0;
    end else begin
      last_q <= last_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign value    = cnt_q;
  assign wrap     = wrap_q;
  assign wrap_nxt = wrap_d;
endmodule

// File: rtl/counter_bank.sv
// Bank of N_CH modulo counters with runtime active-channel count, plus a beep timer
// retriggered by any wrap and a square-wave tone generator for the buzzer.
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int N_CH        = N_CH_DEF,
  parameter int W           = W_DEF,
  parameter int MOD         = MOD_DEF,
  parameter int INIT        = INIT_DEF,
  parameter int BEEP_CYCLES = BEEP_CYCLES_DEF,
  parameter int TONE_HALF   = TONE_HALF_DEF,
  parameter int CW          = $clog2(N_CH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              en,
  input  logic              clear,
  input  logic [CW-1:0]     active_cnt,
  input  logic [N_CH-1:0]   btn,
  output logic [N_CH*W-1:0] values,
  output logic [N_CH-1:0]   wrap,
  output logic              beeping,
  output logic              beep
);
  localparam int TW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
  localparam int HW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(BEEP_CYCLES - 1);
  localparam logic [HW-1:0] TONE_LAST  = HW'(TONE_HALF - 1);

  if (!params_ok(W, MOD, INIT) || N_CH < 1 || N_CH > 16
      || BEEP_CYCLES < 1 || TONE_HALF < 1) begin : g_bad_params
    $error("counter_bank: illegal parameter combination");
  end

  logic [N_CH-1:0] act;
  logic [N_CH-1:0] wrap_nxt;

  always_comb begin
    act = '0;
    for (int i = 0; i < N_CH; i++) act[i] = int'(active_cnt) > i;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    mod_counter_ch #(.W(W), .MOD(MOD), .INIT(INIT)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .en      (en),
      .clear   (clear),
      .active  (act[i]),
      .btn     (btn[i]),
      .value   (values[i*W +: W]),
      .wrap    (wrap[i]),
      .wrap_nxt(wrap_nxt[i])
    );
  end

  logic          beeping_q, beeping_d;
  logic          beep_q, beep_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [HW-1:0] tone_q, tone_d;

  // Driven from the next-cycle wrap so beeping/beep rise together with the wrap pulse
  always_comb begin
    beeping_d = beeping_q;
    timer_d   = timer_q;
    if (|wrap_nxt) begin
      beeping_d = 1'b1;
      timer_d   = TIMER_LOAD;
    end else if (beeping_q) begin
      if (timer_q == '0) beeping_d = 1'b0;
      else               timer_d   = timer_q - TW'(1);
    end

    beep_d = beep_q;
    tone_d = tone_q;
    if (!beeping_d) begin
      beep_d = 1'b0;
      tone_d = '0;
    end else if (!beeping_q) begin
      beep_d = 1'b1;
      tone_d = '0;
    end else if (tone_q == TONE_LAST) begin
      beep_d = ~beep_q;
      tone_d = '0;
    end else begin
      tone_d = tone_q + HW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beeping_q <= 1'b0;
      beep_q    <= 1'b0;
      timer_q   <= '0;
      tone_q    <= '0;
    end else begin
      beeping_q <= beeping_d;
      beep_q    <= beep_d;
      timer_q   <= timer_d;
      tone_q    <= tone_d;
    end
  end

  assign beeping = beeping_q;
  assign beep    = beep_q;
endmodule
